// File: rtl/btn_debounce.sv
// btn_debounce: per-channel synchronizer, tick-sampled debounce,
// edge pulses and hold-to-repeat for N_BTN push buttons.
module btn_debounce #(
    parameter int N_BTN   = 4,
    parameter int DEB_CNT = 4,
    parameter int REP_DLY = 50,
    parameter int REP_PER = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HOLD_DLY = 2'd1,
        HOLD_REP = 2'd2
    } state_t;

    localparam int DW = $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
    localparam logic [15:0] DLY_LAST = 16'(REP_DLY - 1);
    localparam logic [15:0] PER_LAST = 16'(REP_PER - 1);
    // Parked value once the single repeat fired with REP_PER=0;
    // never equal to DLY_LAST since REP_DLY <= 65535.
    localparam logic [15:0] REP_SAT = 16'hFFFF;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          sync_q1;
        logic          sync_q2;
        logic [DW-1:0] deb_cnt;
        logic [DW-1:0] deb_cnt_nxt;
        logic          level_q;
        logic          level_nxt;
        logic          press_q;
        logic          press_nxt;
        logic          release_q;
        logic          release_nxt;
        logic          repeat_q;
        logic          repeat_nxt;
        state_t        state;
        state_t        state_nxt;
        logic [15:0]   rep_cnt;
        logic [15:0]   rep_cnt_nxt;
        logic          diff;

        assign diff = sync_q2 ^ level_q;

        always_comb begin
            deb_cnt_nxt = deb_cnt;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            repeat_nxt  = 1'b0;
            state_nxt   = state;
            rep_cnt_nxt = rep_cnt;
            if (tick) begin
                if (!diff) begin
                    deb_cnt_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    deb_cnt_nxt = '0;
                    level_nxt   = ~level_q;
                    press_nxt   = ~level_q;
                    release_nxt = level_q;
                end else begin
                    deb_cnt_nxt = deb_cnt + DW'(1);
                end

                // A release on the same tick wins over a due repeat.
                if (release_nxt) begin
                    state_nxt   = RELEASED;
                    rep_cnt_nxt = '0;
                end else begin
                    case (state)
                        RELEASED: begin
                            if (press_nxt) begin
                                state_nxt   = HOLD_DLY;
                                rep_cnt_nxt = '0;
                            end
                        end
                        HOLD_DLY: begin
                            if (rep_cnt == DLY_LAST) begin
                                repeat_nxt = 1'b1;
                                if (REP_PER != 0) begin
                                    state_nxt   = HOLD_REP;
                                    rep_cnt_nxt = '0;
                                end else begin
                                    rep_cnt_nxt = REP_SAT;
                                end
                            end else if (rep_cnt != REP_SAT) begin
                                rep_cnt_nxt = rep_cnt + 16'd1;
                            end
                        end
                        HOLD_REP: begin
                            if (rep_cnt == PER_LAST) begin
                                repeat_nxt  = 1'b1;
                                rep_cnt_nxt = '0;
                            end else begin
                                rep_cnt_nxt = rep_cnt + 16'd1;
                            end
                        end
                        default: begin
                            state_nxt   = RELEASED;
                            rep_cnt_nxt = '0;
                        end
                    endcase
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q1   <= 1'b0;
                sync_q2   <= 1'b0;
                deb_cnt   <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                state     <= RELEASED;
                rep_cnt   <= '0;
            end else begin
                sync_q1   <= btn_in[i];
                sync_q2   <= sync_q1;
                deb_cnt   <= deb_cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                repeat_q  <= repeat_nxt;
                state     <= state_nxt;
                rep_cnt   <= rep_cnt_nxt;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios for btn_debounce, default
// parameters plus a REP_PER=0 instance sharing the same stimulus.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] btn_in;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [3:0] lvl0, prs0, rel0, rep0;

    int nvec = 0;
    int nfail = 0;
    int tick_no = 0;
    int press_cnt[4], rel_cnt[4], press_tk[4], rel_tk[4];
    int rep_other;
    int rep_q[$];
    int rep0_q[$];

    btn_debounce dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    btn_debounce #(.REP_PER(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_in),
        .btn_level(lvl0), .btn_press(prs0),
        .btn_release(rel0), .btn_repeat(rep0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 4; i++) begin
            if (btn_press[i]) begin
                press_cnt[i]++;
                press_tk[i] = tick_no;
            end
            if (btn_release[i]) begin
                rel_cnt[i]++;
                rel_tk[i] = tick_no;
            end
            if (i > 0 && btn_repeat[i]) rep_other++;
        end
        if (btn_repeat[0]) rep_q.push_back(tick_no);
        if (rep0[0]) rep0_q.push_back(tick_no);
    end

    task automatic clear_mon();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0;
            press_tk[i] = 0; rel_tk[i] = 0;
        end
        rep_other = 0;
        rep_q.delete();
        rep0_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        tick_no++;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; btn_in = 4'h0;
        #1 rst = 1'b0;
        #1;
        nvec++;
        if (btn_level !== 4'h0 || btn_press !== 4'h0) begin
            nfail++;
            $display("FAIL reset_lvl_prs: %h/%h want 0/0", btn_level, btn_press);
        end
        nvec++;
        if (btn_release !== 4'h0 || btn_repeat !== 4'h0) begin
            nfail++;
            $display("FAIL reset_rel_rep: %h/%h want 0/0", btn_release, btn_repeat);
        end
        nvec++;
        if (lvl0 !== 4'h0 || rep0 !== 4'h0) begin
            nfail++;
            $display("FAIL reset_dut0: %h/%h want 0/0", lvl0, rep0);
        end
        idle(2);
        rst = 1'b1;
        clear_mon();
        run_ticks(6);
        nvec++;
        if (press_cnt.sum() !== 0 || rel_cnt.sum() !== 0 || rep_q.size() !== 0) begin
            nfail++;
            $display("FAIL reset_release_pulse: p=%0d r=%0d rp=%0d want 0",
                     press_cnt.sum(), rel_cnt.sum(), rep_q.size());
        end
    endtask

    task automatic test_glitch();
        clear_mon(); tick_no = 0;
        btn_in[1] = 1'b1; idle(3); run_ticks(3);
        btn_in[1] = 1'b0; idle(3); run_ticks(1);
        btn_in[1] = 1'b1; idle(3); run_ticks(3);
        btn_in[1] = 1'b0; idle(3); run_ticks(4);
        nvec++;
        if (btn_level[1] !== 1'b0) begin
            nfail++;
            $display("FAIL glitch_level: %b want 0", btn_level[1]);
        end
        nvec++;
        if (press_cnt[1] !== 0 || rel_cnt[1] !== 0) begin
            nfail++;
            $display("FAIL glitch_pulses: p=%0d r=%0d want 0/0", press_cnt[1], rel_cnt[1]);
        end
    endtask

    task automatic test_press();
        clear_mon(); tick_no = 0;
        btn_in[0] = 1'b1; idle(3); run_ticks(3);
        nvec++;
        if (btn_level[0] !== 1'b0 || press_cnt[0] !== 0) begin
            nfail++;
            $display("FAIL press_early: lvl=%b p=%0d want 0/0", btn_level[0], press_cnt[0]);
        end
        run_ticks(1);
        nvec++;
        if (btn_level[0] !== 1'b1) begin
            nfail++;
            $display("FAIL press_level: %b want 1", btn_level[0]);
        end
        nvec++;
        if (press_cnt[0] !== 1 || press_tk[0] !== 4) begin
            nfail++;
            $display("FAIL press_pulse: n=%0d at %0d want 1 at 4", press_cnt[0], press_tk[0]);
        end
        nvec++;
        if (press_cnt.sum() !== 1 || rel_cnt.sum() !== 0 || rep_q.size() !== 0) begin
            nfail++;
            $display("FAIL press_other: p=%0d r=%0d rp=%0d want 1/0/0",
                     press_cnt.sum(), rel_cnt.sum(), rep_q.size());
        end
    endtask

    task automatic test_repeat();
        run_ticks(80);
        nvec++;
        if (rep_q.size() !== 4) begin
            nfail++;
            $display("FAIL repeat_count: %0d want 4", rep_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (rep_q[k] !== 54 + 10 * k) begin
                nfail++;
                $display("FAIL repeat_tick%0d: %0d want %0d", k, rep_q[k], 54 + 10 * k);
            end
        end
        nvec++;
        if (rep_other !== 0) begin
            nfail++;
            $display("FAIL repeat_other: %0d want 0", rep_other);
        end
    endtask

    task automatic test_release();
        btn_in[0] = 1'b0; idle(3); run_ticks(4);
        nvec++;
        if (rel_cnt[0] !== 1 || rel_tk[0] !== 88 || btn_level[0] !== 1'b0) begin
            nfail++;
            $display("FAIL release: n=%0d at %0d lvl=%b want 1 at 88 lvl 0",
                     rel_cnt[0], rel_tk[0], btn_level[0]);
        end
        run_ticks(20);
        nvec++;
        if (rep_q.size() !== 4 || rel_cnt[0] !== 1) begin
            nfail++;
            $display("FAIL release_quiet: rp=%0d r=%0d want 4/1", rep_q.size(), rel_cnt[0]);
        end
    endtask

    task automatic test_no_period();
        clear_mon(); tick_no = 0;
        btn_in[0] = 1'b1; idle(3); run_ticks(124);
        nvec++;
        if (rep0_q.size() !== 1 || rep0_q[0] !== 54) begin
            nfail++;
            $display("FAIL noper_repeat: n=%0d first=%0d want 1 at 54",
                     rep0_q.size(), rep0_q[0]);
        end
        nvec++;
        if (rep_q.size() !== 8 || rep_q[7] !== 124) begin
            nfail++;
            $display("FAIL noper_default: n=%0d last=%0d want 8 last 124",
                     rep_q.size(), rep_q[7]);
        end
        btn_in[0] = 1'b0; idle(3); run_ticks(4);
        nvec++;
        if (rel_cnt[0] !== 1 || rel0[0] !== 1'b0) begin
            nfail++;
            $display("FAIL noper_release: n=%0d want 1", rel_cnt[0]);
        end
    endtask

    task automatic test_release_priority();
        clear_mon(); tick_no = 0;
        btn_in[0] = 1'b1; idle(3); run_ticks(60);
        btn_in[0] = 1'b0; idle(3); run_ticks(4);
        nvec++;
        if (rel_cnt[0] !== 1 || rel_tk[0] !== 64) begin
            nfail++;
            $display("FAIL prio_release: n=%0d at %0d want 1 at 64", rel_cnt[0], rel_tk[0]);
        end
        run_ticks(12);
        nvec++;
        if (rep_q.size() !== 1 || rep_q[0] !== 54) begin
            nfail++;
            $display("FAIL prio_repeat: n=%0d first=%0d want 1 at 54", rep_q.size(), rep_q[0]);
        end
    endtask

    task automatic test_reset_mid_hold();
        clear_mon(); tick_no = 0;
        btn_in[0] = 1'b1; idle(3); run_ticks(10);
        nvec++;
        if (btn_level[0] !== 1'b1) begin
            nfail++;
            $display("FAIL midrst_pre: lvl=%b want 1", btn_level[0]);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        nvec++;
        if (btn_level !== 4'h0 || lvl0 !== 4'h0) begin
            nfail++;
            $display("FAIL midrst_async: %h/%h want 0/0", btn_level, lvl0);
        end
        nvec++;
        if ((btn_press | btn_release | btn_repeat) !== 4'h0) begin
            nfail++;
            $display("FAIL midrst_pulses: %h want 0", btn_press | btn_release | btn_repeat);
        end
        @(negedge clk);
        idle(2);
        rst = 1'b1;
        clear_mon(); tick_no = 0;
        idle(3); run_ticks(3);
        nvec++;
        if (press_cnt[0] !== 0 || btn_level[0] !== 1'b0) begin
            nfail++;
            $display("FAIL midrst_early: p=%0d lvl=%b want 0/0", press_cnt[0], btn_level[0]);
        end
        run_ticks(1);
        nvec++;
        if (press_cnt[0] !== 1 || press_tk[0] !== 4 || btn_level[0] !== 1'b1) begin
            nfail++;
            $display("FAIL midrst_repress: n=%0d at %0d lvl=%b want 1 at 4 lvl 1",
                     press_cnt[0], press_tk[0], btn_level[0]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rst = 1'b0; btn_in = 4'h0;
        idle(2);
        rst = 1'b1;
        clear_mon(); tick_no = 0;
        btn_in = 4'hF; idle(3);
        for (int k = 0; k < 8; k++) begin
            tick = 1'b1; tick_no++;
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (press_cnt[i] !== 1 || press_tk[i] !== 4) begin
                nfail++;
                $display("FAIL b2b_press%0d: n=%0d at %0d want 1 at 4", i, press_cnt[i], press_tk[i]);
            end
        end
        btn_in = 4'h0;
        for (int k = 0; k < 8; k++) begin
            tick = 1'b1; tick_no++;
            @(negedge clk);
        end
        tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (rel_cnt[i] !== 1 || rel_tk[i] !== 14) begin
                nfail++;
                $display("FAIL b2b_release%0d: n=%0d at %0d want 1 at 14", i, rel_cnt[i], rel_tk[i]);
            end
        end
        nvec++;
        if (btn_level !== 4'h0) begin
            nfail++;
            $display("FAIL b2b_level: %h want 0", btn_level);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_repeat();
        test_release();
        test_no_period();
        test_release_priority();
        test_reset_mid_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of independent button channels.
REQ-002 SHALL have parameter DEB_CNT, default 4: consecutive differing tick samples required to accept a level change (legal range 1..255).
REQ-003 SHALL have parameter REP_DLY, default 50: ticks from accepted press to first repeat pulse (legal range 1..65535).
REQ-004 SHALL have parameter REP_PER, default 10: ticks between subsequent repeat pulses; 0 disables repeat (legal range 0..65535).
REQ-005 SHALL have port clk  input  1: the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous and active-low.
REQ-007 SHALL have port tick  input  1: one-clk-cycle sample strobe from the upstream clk_div clk_out.
REQ-008 SHALL have port btn_in  input  N_BTN: raw asynchronous button inputs, active-high.
REQ-009 SHALL have port btn_level  output  N_BTN: debounced button level, registered.
REQ-010 SHALL have port btn_press  output  N_BTN: one-clk pulse on accepted 0->1 level change, registered.
REQ-011 SHALL have port btn_release  output  N_BTN: one-clk pulse on accepted 1->0 level change, registered.
REQ-012 SHALL have port btn_repeat  output  N_BTN: one-clk auto-repeat pulse while held, registered.

Function
REQ-013 Each btn_in bit SHALL pass through a 2-flop synchronizer clocked every clk cycle, independent of tick; the result is s[i].
REQ-014 All debounce, repeat and FSM state SHALL advance only in cycles where tick=1; with tick=0 only the synchronizer and pulse clearing occur.
REQ-015 Per channel, on a tick where s[i]!=btn_level[i]: deb_cnt increments; on a tick where s[i]==btn_level[i]: deb_cnt clears to 0.
REQ-016 On the tick where s[i]!=btn_level[i] and deb_cnt==DEB_CNT-1: btn_level[i] SHALL toggle at that edge, deb_cnt clears, and the matching btn_press[i] or btn_release[i] SHALL be 1 in the same following cycle as the new level.
REQ-017 btn_press, btn_release and btn_repeat SHALL each be high for exactly one clk cycle per event and 0 in every other cycle, including consecutive-tick cases (tick=1 in back-to-back cycles).
REQ-018 Per channel FSM states: RELEASED, HOLD_DLY, HOLD_REP; reset state RELEASED.
REQ-019 RELEASED -> HOLD_DLY on accepted press; rep_cnt loaded 0.
REQ-020 HOLD_DLY: rep_cnt increments each tick; on the tick where rep_cnt reaches REP_DLY-1, emit btn_repeat, clear rep_cnt, go to HOLD_REP if REP_PER!=0, else remain in HOLD_DLY with rep_cnt saturated (no further repeats).
REQ-021 HOLD_REP: rep_cnt increments each tick; on the tick where rep_cnt reaches REP_PER-1, emit btn_repeat and clear rep_cnt.
REQ-022 Any state -> RELEASED on accepted release; release takes priority over a repeat due on the same tick (no btn_repeat emitted).
REQ-023 The press tick itself SHALL NOT count toward REP_DLY; the first repeat occurs REP_DLY ticks after the press tick.
REQ-024 A glitch shorter than DEB_CNT ticks SHALL produce no level change and no pulses; a change restarts counting from 0.
REQ-025 deb_cnt width SHALL be $clog2(DEB_CNT+1) minimum; rep_cnt width 16 bits; counters SHALL never wrap.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same cycle.

Reset
REQ-027 While rst=0 all outputs, synchronizer flops, counters and FSMs SHALL be 0/RELEASED immediately, without waiting for clk.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard the event; after release, a still-held button SHALL be re-accepted after DEB_CNT ticks with a fresh btn_press.
REQ-029 Reset deassertion SHALL not itself generate any pulse.

Verification
REQ-030 Defaults, tick every 4 clk, btn_in[0] 0->1 held: btn_level[0]=1 and one btn_press[0] pulse after the 4th tick following synchronizer settle; no other pulses.
REQ-031 btn_in[1] high for 3 ticks then low: btn_level[1] stays 0, no pulses, deb_cnt back to 0.
REQ-032 btn_in[0] held 80 ticks: btn_repeat[0] on ticks 50, 60, 70, 80 after press tick; then release -> btn_release[0] after 4 ticks, no further repeats.
REQ-033 REP_PER=0, hold 120 ticks: exactly one btn_repeat at tick 50.
REQ-034 rst=0 driven asynchronously mid-hold between clk edges: all outputs 0 before next edge; button still high -> new btn_press 4 ticks after reset release.
REQ-035 tick held 1 continuously with all 4 buttons pressed together: all btn_press bits pulse in the same single cycle.
